// File: rtl/arb_weight_tracker.sv
// -----------------------------------------------------------------------------
// arb_weight_tracker
//
// Weighted round-robin bookkeeping that sits beside an arbiter. It counts the
// completed handshakes of each requester and raises a per-requester
// "quota exhausted" flag. The granter uses these flags to mask requesters until
// the round restarts.
//
// Ports:
//   ACLK                     clock
//   ARESETn                  asynchronous active-low reset
//   request                  raw request vector (the same one the granter sees)
//   request_weight           packed weights; requester i at [i*P_WEIGHT_W +: P_WEIGHT_W]
//   grant                    grant vector from the granter (one-hot or zero)
//   grant_hsk                the granted transfer completes this cycle
//   request_weight_completed registered quota-exhausted flags
//   round_done               registered single-cycle pulse when a round restarts
//
// Build option:
//   ARB_WEIGHT_TRACKER_IDLE_CLR_EN  when defined, one idle cycle (request == 0)
//                                   clears any partial-round state and pulses
//                                   round_done.
// -----------------------------------------------------------------------------
module arb_weight_tracker #(
   parameter int P_REQUESTER_NUM = 3,
   parameter int P_WEIGHT_W      = 4
) (
   input  logic                                  ACLK,
   input  logic                                  ARESETn,
   input  logic [P_REQUESTER_NUM-1:0]            request,
   input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] request_weight,
   input  logic [P_REQUESTER_NUM-1:0]            grant,
   input  logic                                  grant_hsk,
   output logic [P_REQUESTER_NUM-1:0]            request_weight_completed,
   output logic                                  round_done
);

   logic [P_WEIGHT_W-1:0]      cnt_q [P_REQUESTER_NUM];
   logic [P_WEIGHT_W-1:0]      cnt_d [P_REQUESTER_NUM];
   logic [P_REQUESTER_NUM-1:0] cmp_q;
   logic [P_REQUESTER_NUM-1:0] cmp_d;
   logic                       round_done_q;
   logic                       round_done_d;
   logic                       clr;
   logic                       idle_clr;

   always_comb begin
      logic [P_WEIGHT_W-1:0] w;
      logic                  ev;
      logic [P_WEIGHT_W:0]   cnt_inc;

      // Round restarts once something is exhausted and nobody is still
      // requesting with quota left.
      clr = (~|(request & ~cmp_q)) & (|cmp_q);

`ifdef ARB_WEIGHT_TRACKER_IDLE_CLR_EN
      begin
         logic any_cnt;
         any_cnt = 1'b0;
         for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
            any_cnt = any_cnt | (cnt_q[i] != '0);
         end
         idle_clr = (request == '0) & (any_cnt | (|cmp_q));
      end
`else
      idle_clr = 1'b0;
`endif

      round_done_d = clr | idle_clr;

      for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
         w       = request_weight[i*P_WEIGHT_W +: P_WEIGHT_W];
         if (w == '0) begin
            w = P_WEIGHT_W'(1);           // zero weight behaves as weight 1
         end
         ev      = grant[i] & grant_hsk;
         cnt_inc = {1'b0, cnt_q[i]} + (P_WEIGHT_W + 1)'(1);
         cnt_d[i] = cnt_q[i];
         cmp_d[i] = cmp_q[i];

         if (idle_clr) begin
            cnt_d[i] = '0;
            cmp_d[i] = 1'b0;
         end else if (clr) begin
            // A handshake coinciding with the clear is the first of the new round.
            cnt_d[i] = ev ? P_WEIGHT_W'(1) : '0;
            cmp_d[i] = ev & (w == P_WEIGHT_W'(1));
         end else if (ev & ~cmp_q[i]) begin
            // >= so a weight lowered below the running count completes on the next handshake.
            if (cnt_inc >= {1'b0, w}) begin
               cnt_d[i] = w;
               cmp_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_inc[P_WEIGHT_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
            cnt_q[i] <= '0;
         end
         cmp_q        <= '0;
         round_done_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         cmp_q        <= cmp_d;
         round_done_q <= round_done_d;
      end
   end

   assign request_weight_completed = cmp_q;
   assign round_done               = round_done_q;

endmodule

// File: tb/tb_arb_weight_tracker.sv
module tb_arb_weight_tracker;

   logic        ACLK;
   logic        ARESETn;
   logic [2:0]  request;
   logic [11:0] request_weight;
   logic [2:0]  grant;
   logic        grant_hsk;
   logic [2:0]  request_weight_completed;
   logic        round_done;

   int total;
   int bad;

   arb_weight_tracker #(
      .P_REQUESTER_NUM(3),
      .P_WEIGHT_W     (4)
   ) dut (
      .ACLK                    (ACLK),
      .ARESETn                 (ARESETn),
      .request                 (request),
      .request_weight          (request_weight),
      .grant                   (grant),
      .grant_hsk               (grant_hsk),
      .request_weight_completed(request_weight_completed),
      .round_done              (round_done)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // advance one active edge and settle
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] exp_cmp, input logic exp_rd);
      chk({tag, "_cmp"}, 32'(request_weight_completed), 32'(exp_cmp));
      chk({tag, "_rd"},  32'(round_done), 32'(exp_rd));
   endtask

   // short reset pulse issued right after an edge
   task automatic pulse_reset();
      ARESETn = 1'b0;
      #2;
      ARESETn = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      ARESETn        = 1'b0;
      request        = '0;
      request_weight = '0;
      grant          = '0;
      grant_hsk      = 1'b0;

      // reset state
      #12;
      chk_out("reset", 3'b000, 1'b0);
      ARESETn = 1'b1;

      // weight 2 exhaustion: weights {2,1,1}
      request_weight = {4'd1, 4'd1, 4'd2};
      request        = 3'b111;
      grant          = 3'b001;
      grant_hsk      = 1'b1;
      tick(); chk_out("w2_hsk1", 3'b000, 1'b0);
      tick(); chk_out("w2_hsk2", 3'b001, 1'b0);

      // round restart
      grant = 3'b010;
      tick(); chk_out("rr_g1", 3'b011, 1'b0);
      grant = 3'b100;
      tick(); chk_out("rr_g2", 3'b111, 1'b0);
      grant = 3'b000; grant_hsk = 1'b0;
      tick(); chk_out("rr_clr", 3'b000, 1'b1);
      tick(); chk_out("rr_after", 3'b000, 1'b0);

      // zero weight with clear coinciding with handshake: weights {0,3,3}
      request_weight = {4'd3, 4'd3, 4'd0};
      request        = 3'b001;
      grant          = 3'b001;
      grant_hsk      = 1'b1;
      tick(); chk_out("zw_hsk1", 3'b001, 1'b0);
      tick(); chk_out("zw_hsk2", 3'b001, 1'b1);
      tick(); chk_out("zw_hsk3", 3'b001, 1'b1);
      grant = 3'b000; grant_hsk = 1'b0;
      tick(); chk_out("zw_clr", 3'b000, 1'b1);
      tick(); chk_out("zw_after", 3'b000, 1'b0);

      // reset mid-round: weights {1,3,3}, requester 0 done, requester 1 at 2 of 3
      request_weight = {4'd3, 4'd3, 4'd1};
      request        = 3'b111;
      grant          = 3'b001;
      grant_hsk      = 1'b1;
      tick(); chk_out("rst_r0", 3'b001, 1'b0);
      grant = 3'b010;
      tick(); tick(); chk_out("rst_r1c2", 3'b001, 1'b0);
      grant = 3'b000; grant_hsk = 1'b0;
      #3;
      ARESETn = 1'b0;
      #1;
      chk_out("rst_async", 3'b000, 1'b0);
      #1;
      ARESETn = 1'b1;
      grant = 3'b010; grant_hsk = 1'b1;
      tick(); chk_out("rst_h1", 3'b000, 1'b0);
      tick(); chk_out("rst_h2", 3'b000, 1'b0);
      tick(); chk_out("rst_h3", 3'b010, 1'b0);

      // idle cycle with partial state on requester 2: weights {2,2,2}
      grant = 3'b000; grant_hsk = 1'b0;
      pulse_reset();
      request_weight = {4'd2, 4'd2, 4'd2};
      request        = 3'b111;
      grant          = 3'b100;
      grant_hsk      = 1'b1;
      tick(); chk_out("idle_c1", 3'b000, 1'b0);
      request = 3'b000; grant = 3'b000; grant_hsk = 1'b0;
`ifdef ARB_WEIGHT_TRACKER_IDLE_CLR_EN
      tick(); chk_out("idle_gap", 3'b000, 1'b1);
`else
      tick(); chk_out("idle_gap", 3'b000, 1'b0);
`endif
      tick(); chk_out("idle_gap2", 3'b000, 1'b0);
      request = 3'b111; grant = 3'b100; grant_hsk = 1'b1;
`ifdef ARB_WEIGHT_TRACKER_IDLE_CLR_EN
      tick(); chk_out("idle_resume", 3'b000, 1'b0);
`else
      tick(); chk_out("idle_resume", 3'b100, 1'b0);
`endif

      // weight lowered mid-round: 5 -> 2 while cnt[0] = 3
      grant = 3'b000; grant_hsk = 1'b0;
      pulse_reset();
      request_weight = {4'd5, 4'd5, 4'd5};
      request        = 3'b111;
      grant          = 3'b001;
      grant_hsk      = 1'b1;
      tick(); tick(); tick(); chk_out("wl_c3", 3'b000, 1'b0);
      grant_hsk = 1'b0;
      tick(); chk_out("wl_nohsk", 3'b000, 1'b0);
      request_weight = {4'd5, 4'd5, 4'd2};
      grant_hsk = 1'b0;
      tick(); chk_out("wl_lowered", 3'b000, 1'b0);
      grant_hsk = 1'b1;
      tick(); chk_out("wl_done", 3'b001, 1'b0);
      // saturated requester granted again: no change
      tick(); chk_out("wl_sat", 3'b001, 1'b0);

      // two grant bits at once count independently: weights {1,1,3}
      grant = 3'b000; grant_hsk = 1'b0;
      pulse_reset();
      request_weight = {4'd3, 4'd1, 4'd1};
      request        = 3'b111;
      grant          = 3'b011;
      grant_hsk      = 1'b1;
      tick(); chk_out("multi", 3'b011, 1'b0);
      grant = 3'b000; grant_hsk = 1'b0;
      tick(); chk_out("multi_hold", 3'b011, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arb_weight_tracker.md
# arb_weight_tracker

Weighted round-robin bookkeeping for the interconnect arbiters. The block counts completed handshakes per requester and raises `request_weight_completed[i]` once requester `i` has used its weight quota in the current round. That vector feeds the priority granter, which masks exhausted requesters until the round restarts. One instance sits beside each arbiter, on the AW, AR and W channel arbitration paths.

## Interface
- `P_REQUESTER_NUM`, 3, number of requesters.
- `P_WEIGHT_W`, 4, width of each per-requester weight and counter.
- `ACLK` in 1: clock.
- `ARESETn` in 1: reset, asynchronous assert, active-low.
- `request` in `P_REQUESTER_NUM`: raw request vector, the same vector the granter sees.
- `request_weight` in `P_REQUESTER_NUM*P_WEIGHT_W`: packed weights, requester `i` at bits `[i*P_WEIGHT_W +: P_WEIGHT_W]`. Sampled every cycle.
- `grant` in `P_REQUESTER_NUM`: grant vector from the granter, one-hot or zero.
- `grant_hsk` in 1: the granted transfer completes this cycle (downstream valid & ready).
- `request_weight_completed` out `P_REQUESTER_NUM`: registered quota-exhausted flags.
- `round_done` out 1: registered single-cycle pulse, round restarted.

## Operation
- State per requester `i`:
  - `cnt[i]`, `P_WEIGHT_W` bits.
  - `cmp[i]`, 1 bit, drives `request_weight_completed[i]`.
- Effective weight `w[i] = (request_weight[i]==0) ? 1 : request_weight[i]`.
- Counting event `ev[i] = grant[i] & grant_hsk`.
- If more than one `grant` bit is set, each bit counts independently. No error is flagged.
- Round-clear condition (combinational, from registered state): `clr = (~|(request & ~cmp)) & (|cmp)`. In words: at least one requester is exhausted, and no requester is both requesting and unexhausted.
- Next state when `clr` = 1:
  - `cnt[i]` becomes `ev[i] ? 1 : 0`.
  - `cmp[i]` becomes `ev[i] & (w[i]==1)`.
  - `round_done` = 1 in the next cycle.
- Next state when `clr` = 0 and `ev[i]` = 1 and `cmp[i]` = 0:
  - If `cnt[i]+1 >= w[i]`, set `cmp[i]` = 1 and hold `cnt[i]` at `w[i]`.
  - Otherwise increment `cnt[i]`.
- Next state when `clr` = 0 and `ev[i]` = 1 and `cmp[i]` = 1: no change. This is a grant through the granter's sole-requester exception; the counter saturates.
- If `w[i]` is lowered mid-round to a value ≤ `cnt[i]`, requester `i` completes on its next `ev[i]`, because the comparison is `>=`.
- Counter arithmetic is unsigned, `P_WEIGHT_W` bits. It never wraps, because it saturates at `w[i]` ≤ 2^`P_WEIGHT_W`−1.
- A requester that drops `request` keeps its `cnt` and `cmp`.

## Timing
- Reset values: all `cnt` = 0, `request_weight_completed` = 0, `round_done` = 0.
- Reset assertion clears immediately and asynchronously. It may occur mid-round; the round then restarts from zero.
- Completion latency: `request_weight_completed[i]` rises on the edge that samples the final `ev[i]`. It is visible one cycle after that handshake.
- Round clear: `cmp` falls and `round_done` pulses one cycle after the cycle in which `clr` is true.
- When `clr` and `ev` coincide, the clear wins and that handshake counts as the first of the new round.
- There is no combinational path from inputs to outputs.

## Configuration
- Macro: `ARB_WEIGHT_TRACKER_IDLE_CLR_EN`.
- Defined: when `request` == 0 for one cycle and any `cnt` ≠ 0 or any `cmp` = 1, all `cnt` and `cmp` clear on the next edge, and `round_done` pulses. An idle bus therefore restarts the round.
- Undefined: partial-round state persists across idle periods, and only the `clr` condition restarts a round.

## Test plan
- **Weight 2 exhaustion.** `P_REQUESTER_NUM`=3, weights {2,1,1}, `request`=3'b111, `grant`=001 with `grant_hsk` for 2 cycles. Expected: `request_weight_completed`=001 one cycle after the 2nd handshake; `round_done` stays 0.
- **Round restart.** Same setup, then `grant` 010 ×1 and 100 ×1. Expected: `completed` goes 011 then 111; the next cycle, `completed`=000 and `round_done`=1 for exactly one cycle.
- **Zero weight and simultaneous clear.** Weight {0,3,3}, `request`=001 only, 3 handshakes on requester 0. Expected: `completed[0]`=1 after the 1st handshake. On the 2nd handshake `clr` is true, so `completed` returns to 1 with `cnt[0]`=1 and `round_done` pulses; the 3rd handshake behaves the same way.
- **Reset mid-round.** `cnt[1]`=2 of 3, assert `ARESETn`=0 mid-cycle. Expected: outputs read 0 before the next `ACLK` edge; after release, 3 more handshakes are needed to complete requester 1.
- **Idle with macro defined.** `cnt[2]`=1, `request`=000 for 1 cycle. Expected: `round_done`=1 and counters cleared. Without the macro: no pulse, and requester 2 completes after 1 more handshake when weight=2.
- **Weight lowered mid-round.** Weight changed from 5 to 2 while `cnt[0]`=3. Expected: the next `ev[0]` sets `completed[0]`=1.
